// File: rtl/ddr_burst_fetcher.sv
// Fetches a linear run of DDR words in bursts that always fit the downstream queue.
// Returned beats go straight to the queue; abort drains the outstanding burst, then flushes.
module ddr_burst_fetcher #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int BURST_LEN  = 8,
  parameter int DEPTH      = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_start,
  input  logic [ADDR_WIDTH-1:0]  io_addr,
  input  logic [LEN_WIDTH-1:0]   io_len,
  input  logic                   io_abort,
  output logic                   io_busy,
  output logic                   io_done,
  output logic                   io_ddr_rd,
  output logic [ADDR_WIDTH-1:0]  io_ddr_addr,
  output logic [7:0]             io_ddr_burstLength,
  input  logic                   io_ddr_waitReq,
  input  logic                   io_ddr_valid,
  input  logic [DATA_WIDTH-1:0]  io_ddr_dout,
  output logic                   io_enq_valid,
  output logic [DATA_WIDTH-1:0]  io_enq_bits,
  input  logic [$clog2(DEPTH):0] io_count,
  output logic                   io_flush
);
  localparam int STRIDE = DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, CHECK, REQ, DATA, DRAIN, FLUSH, DONE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [7:0]            burst, beat_cnt;
  logic                  abort_pending;
  logic                  accept, beat, last_beat, burst_done, room;

  function automatic logic [7:0] burst_of(input logic [LEN_WIDTH-1:0] n);
    return (32'(n) < 32'(BURST_LEN)) ? 8'(n) : 8'(BURST_LEN);
  endfunction

  assign accept     = (state == REQ) && !io_ddr_waitReq;
  assign beat       = io_ddr_valid && ((state == DATA) || (state == DRAIN));
  assign burst_done = (beat_cnt == burst);
  assign last_beat  = beat && ((9'(beat_cnt) + 9'd1) == 9'(burst));
  // Only issue a burst that the queue can absorb in full.
  assign room       = (32'(io_count) + 32'(burst)) <= 32'(DEPTH);

  always_comb begin
    state_nxt    = state;
    io_ddr_rd    = 1'b0;
    io_ddr_addr  = '0;
    io_enq_valid = 1'b0;
    io_done      = 1'b0;
    io_flush     = 1'b0;
    case (state)
      IDLE:  if (io_start) state_nxt = (io_len == '0) ? DONE : CHECK;
      CHECK: begin
        if (io_abort)  state_nxt = FLUSH;
        else if (room) state_nxt = REQ;
      end
      REQ: begin
        // The request is held until accepted even if an abort is pending.
        io_ddr_rd   = 1'b1;
        io_ddr_addr = addr_reg;
        if (accept) state_nxt = (abort_pending || io_abort) ? DRAIN : DATA;
      end
      DATA: begin
        io_enq_valid = io_ddr_valid;
        if (io_abort)       state_nxt = DRAIN;
        else if (last_beat) state_nxt = (remaining == '0) ? DONE : CHECK;
      end
      DRAIN: if (burst_done || last_beat) state_nxt = FLUSH;
      FLUSH: begin
        io_flush  = 1'b1;
        state_nxt = IDLE;
      end
      DONE: begin
        io_done   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign io_busy            = (state != IDLE);
  assign io_enq_bits        = io_ddr_dout;
  assign io_ddr_burstLength = burst;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      addr_reg      <= '0;
      remaining     <= '0;
      burst         <= '0;
      beat_cnt      <= '0;
      abort_pending <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && io_start) begin
        addr_reg      <= io_addr;
        remaining     <= io_len;
        burst         <= burst_of(io_len);
        abort_pending <= 1'b0;
      end
      if ((state == REQ) && io_abort) abort_pending <= 1'b1;
      if (accept) begin
        beat_cnt      <= '0;
        addr_reg      <= addr_reg + ADDR_WIDTH'(32'(burst) * STRIDE);
        remaining     <= remaining - LEN_WIDTH'(burst);
        abort_pending <= 1'b0;
      end else if (beat) begin
        beat_cnt <= beat_cnt + 8'd1;
      end
      // Next burst size is fixed as CHECK is re-entered.
      if ((state == DATA) && (state_nxt == CHECK)) burst <= burst_of(remaining);
    end
  end
endmodule
